// File: rtl/vliw_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vliw_pkg
// Shared definitions for the VLIW issue controller: bundle geometry, slot field
// offsets, the NOP encoding, the decoded slot record and the controller FSM
// state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package vliw_pkg;

  localparam int NSLOT    = 8;
  localparam int NREG     = 32;
  localparam int SLOT_W   = 32;
  localparam int BUNDLE_W = NSLOT * SLOT_W;
  localparam int REG_W    = 5;
  localparam int CNT_W    = 4;

  // Field offsets inside one 32-bit slot word.
  localparam int OP_LSB   = 27;
  localparam int RS_LSB   = 22;
  localparam int RT_LSB   = 17;
  localparam int RD_LSB   = 12;
  localparam int IMM_LSB  = 0;

  localparam logic [SLOT_W-1:0] NOP_WORD = '0;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [11:0] imm12;
  } slot_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HELD  = 2'd1,
    STALL = 2'd2
  } state_e;

  function automatic slot_t slot_decode(input logic [SLOT_W-1:0] w);
    slot_t d;
    d.op    = w[OP_LSB  +: 5];
    d.rs    = w[RS_LSB  +: REG_W];
    d.rt    = w[RT_LSB  +: REG_W];
    d.rd    = w[RD_LSB  +: REG_W];
    d.imm12 = w[IMM_LSB +: 12];
    return d;
  endfunction

endpackage

// File: rtl/vliw_scoreboard.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vliw_scoreboard
// One down-counter per architectural register. A register is pending while its
// counter is nonzero; pending counters decrement every cycle. A set on the same
// edge overrides the decrement.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active-low (all counters to 0)
//   set_en_i   in   NREG   load counter r with set_val_i[r]
//   set_val_i  in   NREGx4 load values
//   pending_o  out  NREG   counter r != 0
// -----------------------------------------------------------------------------
module vliw_scoreboard
  import vliw_pkg::*;
#(
  parameter int NREG = vliw_pkg::NREG
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREG-1:0]             set_en_i,
  input  logic [NREG-1:0][CNT_W-1:0]  set_val_i,
  output logic [NREG-1:0]             pending_o
);

  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    pending_o = '0;
    for (int r = 0; r < NREG; r++) begin
      pending_o[r] = (cnt_q[r] != '0);
      if (set_en_i[r]) begin
        cnt_d[r] = set_val_i[r];
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vliw_issue_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vliw_issue_ctrl
// Issue controller between instruction memory and an 8-slot VLIW datapath.
// Holds one bundle in a skid register and issues it atomically once no slot
// touches a register still pending in the scoreboard.
// Ports:
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous reset, active-low
//   bundle_i        in   NSLOT*32 incoming bundle (slot s = bits [32s+31:32s])
//   bundle_valid_i  in   bundle_i valid
//   bundle_ready_o  out  bundle_i accepted this cycle when valid
//   flush_i         in   drop the held bundle (branch redirect)
//   issue_valid_o   out  NSLOT per-slot issue strobe (registered)
//   issue_bundle_o  out  issued bundle, zero when nothing issues (registered)
//   stall_o         out  held bundle blocked by a hazard in STALL
//   waw_err_o       out  pulse: the issued bundle wrote one rd from two slots
//   stall_cnt_o     out  16-bit saturating stall-cycle count
// -----------------------------------------------------------------------------
module vliw_issue_ctrl
  import vliw_pkg::*;
#(
  parameter int                  NSLOT = vliw_pkg::NSLOT,
  parameter int                  NREG  = vliw_pkg::NREG,
  parameter logic [4*NSLOT-1:0]  LAT   = {NSLOT{4'd1}}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NSLOT*SLOT_W-1:0] bundle_i,
  input  logic                    bundle_valid_i,
  output logic                    bundle_ready_o,
  input  logic                    flush_i,
  output logic [NSLOT-1:0]        issue_valid_o,
  output logic [NSLOT*SLOT_W-1:0] issue_bundle_o,
  output logic                    stall_o,
  output logic                    waw_err_o,
  output logic [15:0]             stall_cnt_o
);

  localparam int BW = NSLOT * SLOT_W;

  state_e                      state_q, state_d;
  logic [BW-1:0]               hold_q;
  logic [NSLOT-1:0]            issue_valid_q, issue_valid_d;
  logic [BW-1:0]               issue_bundle_q, issue_bundle_d;
  logic                        waw_q, waw_d;
  logic [15:0]                 stall_cnt_q, stall_cnt_d;

  slot_t                       slot [NSLOT];
  logic [NSLOT-1:0]            live;
  logic [NREG-1:0]             pending;
  logic [NREG-1:0]             set_en;
  logic [NREG-1:0][CNT_W-1:0]  set_val;
  logic                        dup_rd;
  logic                        hold_valid, hazard, issue, accept, load_hold, stall;

  // Decode of the held bundle.
  always_comb begin
    for (int s = 0; s < NSLOT; s++) begin
      slot[s] = slot_decode(hold_q[s*SLOT_W +: SLOT_W]);
      live[s] = (hold_q[s*SLOT_W +: SLOT_W] != NOP_WORD);
    end
  end

  // Slots of one bundle never hazard against each other: only the scoreboard
  // state from before this bundle is consulted.
  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < NSLOT; s++) begin
      if (live[s] && (pending[slot[s].rs] || pending[slot[s].rt] ||
                      pending[slot[s].rd])) begin
        hazard = 1'b1;
      end
    end
  end

  // Destination counter loads; duplicate rd keeps the longest latency.
  always_comb begin : set_calc
    logic [CNT_W-1:0] lat_m1;
    set_en  = '0;
    set_val = '0;
    dup_rd  = 1'b0;
    lat_m1  = '0;
    for (int s = 0; s < NSLOT; s++) begin
      lat_m1 = LAT[4*s +: 4] - 4'd1;
      if (live[s]) begin
        if (set_en[slot[s].rd]) begin
          dup_rd = 1'b1;
          if (lat_m1 > set_val[slot[s].rd]) set_val[slot[s].rd] = lat_m1;
        end else begin
          set_en[slot[s].rd]  = 1'b1;
          set_val[slot[s].rd] = lat_m1;
        end
      end
    end
  end

  assign hold_valid     = (state_q != EMPTY);
  assign issue          = hold_valid && !hazard && !flush_i;
  assign bundle_ready_o = !hold_valid || issue || flush_i;
  assign accept         = bundle_valid_i && bundle_ready_o;
  // A bundle handshaken together with flush_i belongs to the squashed path
  // and is consumed without being held.
  assign load_hold      = accept && !flush_i;
  assign stall          = (state_q == STALL) && hazard && !flush_i;

  vliw_scoreboard #(.NREG(NREG)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en_i  (set_en & {NREG{issue}}),
    .set_val_i (set_val),
    .pending_o (pending)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (load_hold) state_d = HELD;
      HELD, STALL: begin
        if (hazard) state_d = STALL;
        else        state_d = load_hold ? HELD : EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) state_d = EMPTY;
  end

  always_comb begin
    issue_valid_d  = issue ? live : '0;
    issue_bundle_d = issue ? hold_q : '0;
    waw_d          = issue && dup_rd;
    stall_cnt_d    = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= EMPTY;
      issue_valid_q  <= '0;
      issue_bundle_q <= '0;
      waw_q          <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      issue_valid_q  <= issue_valid_d;
      issue_bundle_q <= issue_bundle_d;
      waw_q          <= waw_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  // Skid data needs no reset: it is only observed while state_q != EMPTY.
  always_ff @(posedge clk) begin
    if (load_hold) hold_q <= bundle_i;
  end

  assign issue_valid_o  = issue_valid_q;
  assign issue_bundle_o = issue_bundle_q;
  assign waw_err_o      = waw_q;
  assign stall_o        = stall;
  assign stall_cnt_o    = stall_cnt_q;

endmodule
